// File: rtl/adaptive_threshold.sv
// ============================================================================
// Module  : adaptive_threshold
// Brief   : Raster-scan binarizer: pixel + OFFSET > local mean -> 8'hFF, else 8'h00
// Revision: 1.0
// ============================================================================
`default_nettype none

module adaptive_threshold #(
  parameter int WIDTH_BITS  = 7,
  parameter int HEIGHT_BITS = 7,
  parameter int OFFSET      = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   iStart,
  output logic [WIDTH_BITS-1:0]  oImageCol,
  output logic [HEIGHT_BITS-1:0] oImageRow,
  input  logic [7:0]             iImageData,
  output logic [WIDTH_BITS-1:0]  oMeanCol,
  output logic [HEIGHT_BITS-1:0] oMeanRow,
  input  logic [7:0]             iMeanData,
  output logic [WIDTH_BITS-1:0]  oResultCol,
  output logic [HEIGHT_BITS-1:0] oResultRow,
  output logic [7:0]             oResultData,
  output logic                   oResultWren,
  output logic                   finished
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [WIDTH_BITS-1:0]  COL_LAST   = '1;
  localparam logic [HEIGHT_BITS-1:0] ROW_LAST   = '1;
  localparam logic [8:0]             OFFSET_EXT = 9'(OFFSET);

  logic [1:0]             state;
  logic [WIDTH_BITS-1:0]  col;
  logic [HEIGHT_BITS-1:0] row;
  logic                   addr_valid;
  logic                   data_valid;
  logic [WIDTH_BITS-1:0]  data_col;
  logic [HEIGHT_BITS-1:0] data_row;
  logic                   drain_cnt;

  // 9-bit compare so pixel + OFFSET can exceed 255 without wrapping
  logic [8:0] biased;
  logic       foreground;
  assign biased     = {1'b0, iImageData} + OFFSET_EXT;
  assign foreground = biased > {1'b0, iMeanData};

  assign oImageCol = col;
  assign oImageRow = row;
  assign oMeanCol  = col;
  assign oMeanRow  = row;

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= S_IDLE;
      col         <= '0;
      row         <= '0;
      addr_valid  <= 1'b0;
      data_valid  <= 1'b0;
      data_col    <= '0;
      data_row    <= '0;
      drain_cnt   <= 1'b0;
      oResultCol  <= '0;
      oResultRow  <= '0;
      oResultData <= 8'h00;
      oResultWren <= 1'b0;
      finished    <= 1'b0;
    end else begin
      // Address copy travels with the memory read so results name their pixel
      data_valid  <= addr_valid;
      data_col    <= col;
      data_row    <= row;
      oResultWren <= data_valid;
      if (data_valid) begin
        oResultCol  <= data_col;
        oResultRow  <= data_row;
        oResultData <= foreground ? 8'hFF : 8'h00;
      end

      case (state)
        S_IDLE: begin
          if (iStart) begin
            state      <= S_RUN;
            col        <= '0;
            row        <= '0;
            addr_valid <= 1'b1;
          end
        end
        S_RUN: begin
          if (col == COL_LAST && row == ROW_LAST) begin
            state      <= S_DRAIN;
            addr_valid <= 1'b0;
            drain_cnt  <= 1'b0;
          end else begin
            col <= col + 1'b1;
            if (col == COL_LAST) begin
              row <= row + 1'b1;
            end
          end
        end
        S_DRAIN: begin
          if (drain_cnt) begin
            state    <= S_DONE;
            finished <= 1'b1;
          end else begin
            drain_cnt <= 1'b1;
          end
        end
        S_DONE: begin
          state <= S_DONE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_adaptive_threshold.sv
// Bench for adaptive_threshold: two instances (OFFSET=8 and OFFSET=255) on a 4x4 image.
`default_nettype none

module tb_adaptive_threshold;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0] start;
  logic [1:0] img_col  [2];
  logic [1:0] img_row  [2];
  logic [1:0] mean_col [2];
  logic [1:0] mean_row [2];
  logic [1:0] res_col  [2];
  logic [1:0] res_row  [2];
  logic [7:0] res_data [2];
  logic [7:0] img_q    [2];
  logic [7:0] mean_q   [2];
  logic [1:0] wren;
  logic [1:0] fin;

  logic [7:0] img_mem  [2][16];
  logic [7:0] mean_mem [2][16];

  int checks   = 0;
  int failures = 0;
  logic [11:0] sb_q[$];

  adaptive_threshold #(.WIDTH_BITS(2), .HEIGHT_BITS(2), .OFFSET(8)) dut0 (
    .clock(clk), .reset(rst), .iStart(start[0]),
    .oImageCol(img_col[0]), .oImageRow(img_row[0]), .iImageData(img_q[0]),
    .oMeanCol(mean_col[0]), .oMeanRow(mean_row[0]), .iMeanData(mean_q[0]),
    .oResultCol(res_col[0]), .oResultRow(res_row[0]), .oResultData(res_data[0]),
    .oResultWren(wren[0]), .finished(fin[0])
  );

  adaptive_threshold #(.WIDTH_BITS(2), .HEIGHT_BITS(2), .OFFSET(255)) dut1 (
    .clock(clk), .reset(rst), .iStart(start[1]),
    .oImageCol(img_col[1]), .oImageRow(img_row[1]), .iImageData(img_q[1]),
    .oMeanCol(mean_col[1]), .oMeanRow(mean_row[1]), .iMeanData(mean_q[1]),
    .oResultCol(res_col[1]), .oResultRow(res_row[1]), .oResultData(res_data[1]),
    .oResultWren(wren[1]), .finished(fin[1])
  );

  // Registered ROM / RAM models with one cycle of read latency
  always @(posedge clk) begin
    img_q[0]  <= img_mem[0][{img_row[0], img_col[0]}];
    mean_q[0] <= mean_mem[0][{mean_row[0], mean_col[0]}];
    img_q[1]  <= img_mem[1][{img_row[1], img_col[1]}];
    mean_q[1] <= mean_mem[1][{mean_row[1], mean_col[1]}];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] model(input int s, input int off, input int idx);
    int p, m;
    p = int'(img_mem[s][idx]);
    m = int'(mean_mem[s][idx]);
    return ((p + off) > m) ? 8'hFF : 8'h00;
  endfunction

  task automatic pulse_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // abort_after > 0 asserts reset right after that many writes have been observed
  task automatic scan(input int s, input int off, input int abort_after);
    int writes;
    int first;
    int last;
    int fin_edge;
    logic [11:0] exp;
    writes = 0; first = -1; last = -1; fin_edge = -1;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        sb_q.push_back({2'(c), 2'(r), model(s, off, r * 4 + c)});
    start[s] = 1'b1;
    @(posedge clk);
    #1;
    start[s] = 1'b0;
    for (int k = 1; k <= 24; k++) begin
      @(posedge clk);
      #1;
      if (wren[s]) begin
        exp = (sb_q.size() > 0) ? sb_q.pop_front() : 12'hxxx;
        check("write", {20'h0, res_col[s], res_row[s], res_data[s]}, {20'h0, exp});
        writes++;
        if (first < 0) first = k;
        last = k;
        if (writes == abort_after) begin
          rst = 1'b1;
          @(posedge clk);
          #1;
          check("abort_wren", 32'(wren[s]), 32'd0);
          check("abort_finished", 32'(fin[s]), 32'd0);
          check("abort_addr", {28'h0, img_col[s], img_row[s]}, 32'd0);
          rst = 1'b0;
          sb_q.delete();
          return;
        end
      end
      if (fin[s] && fin_edge < 0) fin_edge = k;
    end
    check("write_count", 32'(writes), 32'd16);
    check("first_write_edge", 32'(first), 32'd2);
    check("last_write_edge", 32'(last), 32'd17);
    check("finished_edge", 32'(fin_edge), 32'd18);
    check("queue_drained", 32'(sb_q.size()), 32'd0);
  endtask

  initial begin
    int cnt;
    start = 2'b00;
    for (int i = 0; i < 16; i++) begin
      img_mem[0][i] = 8'd0; mean_mem[0][i] = 8'd0;
      img_mem[1][i] = 8'd0; mean_mem[1][i] = 8'd0;
    end
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      check("reset_wren", 32'(wren[s]), 32'd0);
      check("reset_finished", 32'(fin[s]), 32'd0);
      check("reset_result", {20'h0, res_col[s], res_row[s], res_data[s]}, 32'd0);
      check("reset_addr", {28'h0, img_col[s], img_row[s]}, 32'd0);
    end
    rst = 1'b0;

    // Idle with iStart low: nothing happens
    cnt = 0;
    repeat (100) begin
      @(posedge clk);
      #1;
      if (wren[0]) cnt++;
    end
    check("idle_no_write", 32'(cnt), 32'd0);
    check("idle_finished", 32'(fin[0]), 32'd0);

    // Flat image, equal mean: all foreground
    for (int i = 0; i < 16; i++) begin img_mem[0][i] = 8'd100; mean_mem[0][i] = 8'd100; end
    scan(0, 8, 0);

    // iStart toggling in DONE is ignored
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      start[0] = i[0];
      @(posedge clk);
      #1;
      if (wren[0]) cnt++;
    end
    start[0] = 1'b0;
    check("done_no_write", 32'(cnt), 32'd0);
    check("done_finished_held", 32'(fin[0]), 32'd1);
    pulse_reset();

    // Equality and near-threshold pixels on the first row
    img_mem[0][0] = 8'd92; img_mem[0][1] = 8'd93; img_mem[0][2] = 8'd50; img_mem[0][3] = 8'd255;
    scan(0, 8, 0);
    pulse_reset();

    // Gradient with mean exactly pixel+8: all background, raster order
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        img_mem[0][r * 4 + c]  = 8'(c * 16 + r * 64);
        mean_mem[0][r * 4 + c] = 8'(c * 16 + r * 64 + 8);
      end
    scan(0, 8, 0);
    pulse_reset();

    // Random image, reset after 5th write, then a full fresh scan
    for (int i = 0; i < 16; i++) begin
      img_mem[0][i]  = 8'($urandom_range(255));
      mean_mem[0][i] = 8'($urandom_range(255));
    end
    scan(0, 8, 5);
    scan(0, 8, 0);

    // OFFSET=255 instance: no 8-bit overflow, equality is background
    for (int i = 0; i < 16; i++) begin
      img_mem[1][i]  = i[0] ? 8'd0 : 8'd255;
      mean_mem[1][i] = 8'd255;
    end
    scan(1, 255, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
